// File: rtl/unslice_stream.sv
// Streaming depth-to-space: one packed half-resolution pixel (4 groups of K channels)
// in, full-resolution raster pixels out. Odd-row groups wait in a W/2-entry line buffer.
module unslice_stream #(
  parameter int W          = 4,
  parameter int H          = 4,
  parameter int K          = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4*K*DATA_WIDTH-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [K*DATA_WIDTH-1:0]     out_data,
  output logic                        out_eol,
  output logic                        out_last,
  output logic                        dbg_state_o
);
  // Handshake: a beat moves on either side exactly when valid && ready at a rising
  // edge; out_valid/out_data hold until taken, in_ready never looks at in_valid.
  localparam int GW = K * DATA_WIDTH;
  localparam int HW = W / 2;
  localparam int HH = H / 2;
  localparam int XW = (HW > 1) ? $clog2(HW) : 1;
  localparam int YW = (HH > 1) ? $clog2(HH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HH - 1);

  typedef enum logic {ST_EVEN = 1'b0, ST_ODD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic            hold_vld_q, hold_vld_d;
  logic [XW-1:0]   in_x_q, in_x_d;
  logic [XW-1:0]   out_x_q, out_x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [4*GW-1:0] hold_q;
  logic [2*GW-1:0] buf_q [HW];
  logic [2*GW-1:0] buf_rd;
  logic            last_col;
  logic            in_fire;
  logic            out_fire;

  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EVEN;
      phase_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      in_x_q     <= '0;
      out_x_q    <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_vld_q <= hold_vld_d;
      in_x_q     <= in_x_d;
      out_x_q    <= out_x_d;
      y_q        <= y_d;
    end
  end

  // Data storage carries no reset; the valid flag and state decide what is live.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      hold_q         <= in_data;
      buf_q[in_x_q]  <= {in_data[3*GW-1 -: GW], in_data[GW-1:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hold_vld_d = hold_vld_q;
    in_x_d     = in_x_q;
    out_x_d    = out_x_q;
    y_d        = y_q;
    if (out_fire) begin
      phase_d = !phase_q;
      if (phase_q) begin
        out_x_d = last_col ? '0 : out_x_q + XW'(1);
        if (state_q == ST_EVEN) hold_vld_d = 1'b0;
        if (last_col) begin
          if (state_q == ST_EVEN) begin
            state_d = ST_ODD;
          end else begin
            state_d = ST_EVEN;
            y_d     = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          end
        end
      end
    end
    // A same-cycle refill wins over the clear above, so even rows stream without bubbles.
    if (in_fire) begin
      hold_vld_d = 1'b1;
      in_x_d     = (in_x_q == X_LAST) ? '0 : in_x_q + XW'(1);
    end
  end

  always_comb begin
    last_col  = (out_x_q == X_LAST);
    buf_rd    = buf_q[out_x_q];
    in_ready  = 1'b0;
    out_valid = 1'b1;
    if (state_q == ST_EVEN) begin
      out_valid = hold_vld_q;
      in_ready  = !hold_vld_q || (phase_q && out_ready && !last_col);
      out_data  = phase_q ? hold_q[2*GW-1 -: GW] : hold_q[4*GW-1 -: GW];
    end else begin
      out_data  = phase_q ? buf_rd[GW-1:0] : buf_rd[2*GW-1 -: GW];
    end
    out_eol  = out_valid && phase_q && last_col;
    out_last = out_eol && (state_q == ST_ODD) && (y_q == Y_LAST);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

endmodule

// File: tb/tb_unslice_stream.sv
// Randomized bench for unslice_stream: a raster model built from the group map
// (and a slice/unslice round trip) is compared against the collected output stream.
module tb_unslice_stream;
  localparam int W = 4, H = 4, K = 3, DW = 16;
  localparam int GW = K * DW, IW = 4 * GW;
  localparam int HW = W / 2, HH = H / 2, NP = HW * HH, NB = W * H;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [GW-1:0] out_data;
  logic          out_eol;
  logic          out_last;
  logic          dbg_state;

  unslice_stream #(.W(W), .H(H), .K(K), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_last(out_last), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc;
  logic [IW-1:0]   src_q[$];
  logic [GW+1:0]   exp_q[$];
  logic [GW+1:0]   got_q[$];
  logic [GW-1:0]   x_img [3][H][W];

  function automatic logic [IW-1:0] put_field(logic [IW-1:0] p, int g, int c, logic [DW-1:0] v);
    p[IW-1-(g*K+c)*DW -: DW] = v;
    return p;
  endfunction

  // Pixel p, group g, channel c carries {p, g, c}.
  function automatic void build_src_pattern(int frames);
    logic [IW-1:0] p;
    src_q.delete();
    for (int i = 0; i < frames * NP; i++) begin
      p = '0;
      for (int g = 0; g < 4; g++)
        for (int c = 0; c < K; c++)
          p = put_field(p, g, c, {8'(i), 4'(g), 4'(c)});
      src_q.push_back(p);
    end
  endfunction

  // Output (r,c) comes from input pixel (r/2, c/2), group (r odd) + 2*(c odd).
  function automatic void build_exp_groups(int frames);
    logic [IW-1:0] p;
    int g;
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          p = src_q[f*NP + (r/2)*HW + c/2];
          g = (r % 2) + 2 * (c % 2);
          exp_q.push_back({(r == H-1) && (c == W-1), c == W-1, p[IW-1-g*GW -: GW]});
        end
  endfunction

  task automatic run_frames(input int nexp, input int gap_pct, input int rdy_pct, input bit chk_gap);
    got_q.delete();
    n_acc = 0;
    fork
      begin
        int  idx = 0;
        int  cyc = 0;
        bit  fire;
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = src_q[0];
        while (idx < src_q.size() && cyc < BUDGET) begin
          @(negedge clk);
          fire = in_valid && in_ready;
          @(posedge clk); #1;
          if (fire) begin idx++; n_acc++; end
          cyc++;
          if (idx < src_q.size()) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = src_q[idx];
          end
        end
        in_valid = 1'b0;
      end
      begin
        int cyc = 0;
        int gap_cd = -1;
        bit stalled = 0;
        logic [GW-1:0] held = '0;
        int b, f, w, r, c, need;
        bit exp_v;
        out_ready = ($urandom_range(99) < rdy_pct);
        while (got_q.size() < nexp && cyc < BUDGET) begin
          @(negedge clk);
          b = got_q.size(); f = b / NB; w = b % NB; r = w / W; c = w % W;
          need  = f*NP + (r/2)*HW + c/2;
          exp_v = (r % 2 == 1) || (n_acc > need);
          n_checks++;
          if (out_valid !== exp_v) $display("FAIL out_valid beat%0d got %b exp %b", b, out_valid, exp_v);
          else n_pass++;
          if (r % 2 == 1) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL in_ready_odd_row beat%0d got %b exp 0", b, in_ready);
            else n_pass++;
          end
          if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held)
              $display("FAIL stall_hold beat%0d got v=%b %h exp v=1 %h", b, out_valid, out_data, held);
            else n_pass++;
          end
          if (chk_gap && gap_cd > 0) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL in_ready_gap beat%0d got %b exp 0", b, in_ready);
            else n_pass++;
            gap_cd--;
          end else if (chk_gap && gap_cd == 0) begin
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL in_ready_resume beat%0d got %b exp 1", b, in_ready);
            else n_pass++;
            gap_cd = -1;
          end
          stalled = out_valid && !out_ready;
          held    = out_data;
          if (out_valid && out_ready) begin
            got_q.push_back({out_last, out_eol, out_data});
            if (chk_gap && (r % 2 == 0) && (c == W-1)) gap_cd = W;
          end
          @(posedge clk); #1;
          out_ready = ($urandom_range(99) < rdy_pct);
          cyc++;
        end
        if (cyc >= BUDGET) begin
          n_checks++;
          $display("FAIL timeout got %0d beats exp %0d", got_q.size(), nexp);
        end
        out_ready = 1'b0;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_eol !== 1'b0) $display("FAIL reset_out_eol got %b exp 0", out_eol); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state got %b exp 0", dbg_state); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_constant_groups();
    logic [IW-1:0] p;
    logic [DW-1:0] v;
    int r, c;
    p = '0;
    for (int g = 0; g < 4; g++)
      for (int ch = 0; ch < K; ch++)
        p = put_field(p, g, ch, (g == 0) ? 16'h0001 : (g == 1) ? 16'h0003 : (g == 2) ? 16'h0002 : 16'h0004);
    src_q.delete();
    for (int i = 0; i < NP; i++) src_q.push_back(p);
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      r = b / W; c = b % W;
      v = (r % 2 == 0) ? ((c % 2 == 0) ? 16'h0001 : 16'h0002) : ((c % 2 == 0) ? 16'h0003 : 16'h0004);
      exp_q.push_back({b == NB-1, (b % W) == W-1, {K{v}}});
    end
    run_frames(NB, 0, 100, 1'b0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL const_count got %0d exp %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL const_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_raster(input string name, input int gap_pct, input int rdy_pct, input bit chk_gap);
    build_src_pattern(1);
    build_exp_groups(1);
    run_frames(NB, gap_pct, rdy_pct, chk_gap);
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL %s_count got %0d exp %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL %s_beat%0d got %h exp %h", name, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    int idx = 0, beats = 0, cyc = 0;
    bit fo, fi;
    build_src_pattern(1);
    in_valid  = 1'b1;
    in_data   = src_q[0];
    out_ready = 1'b1;
    while (beats < 5 && cyc < 200) begin
      @(negedge clk);
      fo = out_valid && out_ready;
      fi = in_valid && in_ready;
      @(posedge clk); #1;
      if (fo) beats++;
      if (fi && idx < NP - 1) idx++;
      in_data = src_q[idx];
      cyc++;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_eol !== 1'b0 || out_last !== 1'b0)
      $display("FAIL midrst_flags got eol=%b last=%b exp 0 0", out_eol, out_last); else n_pass++;
    @(posedge clk); #1;
    test_raster("midrst", 0, 100, 1'b0);
  endtask

  task automatic test_back_to_back_roundtrip();
    logic [IW-1:0] p;
    int n_last = 0;
    src_q.delete();
    exp_q.delete();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          for (int ch = 0; ch < K; ch++)
            x_img[f][r][c][GW-1-ch*DW -: DW] = DW'($urandom);
    // Slice: each 2x2 block becomes {(0,0),(1,0),(0,1),(1,1)} from the MSB.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < HH; i++)
        for (int j = 0; j < HW; j++) begin
          p = {x_img[f][2*i][2*j], x_img[f][2*i+1][2*j], x_img[f][2*i][2*j+1], x_img[f][2*i+1][2*j+1]};
          src_q.push_back(p);
        end
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back({(r == H-1) && (c == W-1), c == W-1, x_img[f][r][c]});
    run_frames(3 * NB, 15, 75, 1'b0);
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rt_count got %0d exp %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rt_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      else n_pass++;
      if (got_q[i][GW+1]) n_last++;
    end
    n_checks++;
    if (n_last != 3) $display("FAIL rt_last_count got %0d exp 3", n_last);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_constant_groups();
    test_raster("raster", 0, 100, 1'b1);
    test_raster("stall", 0, 50, 1'b0);
    test_raster("gaps", 40, 100, 1'b0);
    test_reset_midframe();
    test_back_to_back_roundtrip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
